// File: rtl/manual_drive_if.sv
// Driver-side bundle for the manual driving controller: pedal/gear/button
// inputs toward the controller and the state and command outputs back.
interface manual_drive_if;
    logic       manual_enable;
    logic       clutch;
    logic       throttle;
    logic       brake;
    logic       bu_left;
    logic       bu_right;
    logic       reverse;
    logic [1:0] state;
    logic [1:0] next_state;
    logic       turn_left_signal;
    logic       turn_right_signal;
    logic       move_backward_signal;
    logic       move_forward_signal;

    modport master (
        output manual_enable, clutch, throttle, brake, bu_left, bu_right, reverse,
        input  state, next_state, turn_left_signal, turn_right_signal,
               move_backward_signal, move_forward_signal
    );

    modport slave (
        input  manual_enable, clutch, throttle, brake, bu_left, bu_right, reverse,
        output state, next_state, turn_left_signal, turn_right_signal,
               move_backward_signal, move_forward_signal
    );
endinterface

// File: rtl/manual_drive.sv
// Manual-transmission vehicle FSM (not-started / started / moving) with
// direction latch and turn decode. Optional gearbox stall: MANUAL_REVERSE_STALL_EN.
module manual_drive (
    input  logic           clk,
    input  logic           rst,
    manual_drive_if.slave  bus_io
);
    typedef enum logic [1:0] {
        ST_NS = 2'b00,
        ST_S  = 2'b01,
        ST_M  = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   dir_q;
    logic   turn_left_q;
    logic   turn_right_q;
    logic   turn_left_d;
    logic   turn_right_d;

    always_comb begin
        state_d = ST_NS;
        if (bus_io.manual_enable) begin
            case (state_q)
                ST_NS: begin
                    if (bus_io.throttle && bus_io.clutch && !bus_io.brake)
                        state_d = ST_S;
                    else
                        state_d = ST_NS;
                end
                ST_S: begin
                    if (bus_io.brake)
                        state_d = ST_NS;
                    else if (bus_io.throttle && !bus_io.clutch)
                        state_d = ST_M;
                    else
                        state_d = ST_S;
                end
                ST_M: begin
                    // Clutch always wins; throttle release alone keeps us moving.
                    if (bus_io.clutch)
                        state_d = ST_S;
`ifdef MANUAL_REVERSE_STALL_EN
                    else if (bus_io.reverse != dir_q)
                        state_d = ST_NS;
`endif
                    else if (bus_io.brake)
                        state_d = ST_NS;
                    else
                        state_d = ST_M;
                end
                default: state_d = ST_NS;
            endcase
        end
    end

    always_comb begin
        turn_left_d  = bus_io.manual_enable && (state_q != ST_NS)
                       && bus_io.bu_left && !bus_io.bu_right;
        turn_right_d = bus_io.manual_enable && (state_q != ST_NS)
                       && bus_io.bu_right && !bus_io.bu_left;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_NS;
            dir_q        <= 1'b0;
            turn_left_q  <= 1'b0;
            turn_right_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            turn_left_q  <= turn_left_d;
            turn_right_q <= turn_right_d;
            // Direction is sampled only when the car starts moving.
            if (state_q == ST_S && state_d == ST_M)
                dir_q <= bus_io.reverse;
        end
    end

    assign bus_io.state                = state_q;
    assign bus_io.next_state           = state_d;
    assign bus_io.turn_left_signal     = turn_left_q;
    assign bus_io.turn_right_signal    = turn_right_q;
    assign bus_io.move_forward_signal  = (state_q == ST_M) && !dir_q;
    assign bus_io.move_backward_signal = (state_q == ST_M) && dir_q;
endmodule

// File: tb/tb_manual_drive.sv
// Directed bench for manual_drive: scoreboard of expected post-edge outputs.
module tb_manual_drive;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    manual_drive_if dif ();

    manual_drive dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       fwd;
        logic       bwd;
        logic       tl;
        logic       tr;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // pedals = {throttle, reverse, clutch, brake}; btn = {bu_left, bu_right}
    task automatic step(input string tag, input logic en, input logic [3:0] pedals,
                        input logic [1:0] btn, input logic [1:0] st,
                        input logic fwd, input logic bwd, input logic tl, input logic tr);
        exp_t e;
        exp_t got;
        dif.manual_enable = en;
        dif.throttle      = pedals[3];
        dif.reverse       = pedals[2];
        dif.clutch        = pedals[1];
        dif.brake         = pedals[0];
        dif.bu_left       = btn[1];
        dif.bu_right      = btn[0];
        e.tag = tag; e.st = st; e.fwd = fwd; e.bwd = bwd; e.tl = tl; e.tr = tr;
        sb_q.push_back(e);
        #1;
        chk({tag, ".next"}, dif.next_state, st);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk({got.tag, ".state"}, dif.state, got.st);
        chk({got.tag, ".fwd"}, {1'b0, dif.move_forward_signal}, {1'b0, got.fwd});
        chk({got.tag, ".bwd"}, {1'b0, dif.move_backward_signal}, {1'b0, got.bwd});
        chk({got.tag, ".tl"}, {1'b0, dif.turn_left_signal}, {1'b0, got.tl});
        chk({got.tag, ".tr"}, {1'b0, dif.turn_right_signal}, {1'b0, got.tr});
        $display("step %-10s en=%0b ped=%b btn=%b state=%0d f=%0b b=%0b l=%0b r=%0b",
                 tag, en, pedals, btn, dif.state, dif.move_forward_signal,
                 dif.move_backward_signal, dif.turn_left_signal, dif.turn_right_signal);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        dif.manual_enable = 1'b0;
        dif.throttle = 1'b0; dif.reverse = 1'b0; dif.clutch = 1'b0; dif.brake = 1'b0;
        dif.bu_left = 1'b0; dif.bu_right = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.state", dif.state, 2'b00);
        chk("rst.fwd", {1'b0, dif.move_forward_signal}, 2'b00);
        chk("rst.tl", {dif.turn_left_signal, dif.turn_right_signal}, 2'b00);
        rst = 1'b0;
        @(posedge clk);
        #1;

        step("start",     1'b1, 4'b1010, 2'b00, 2'b01, 0, 0, 0, 0);
        step("go_fwd",    1'b1, 4'b1000, 2'b00, 2'b10, 1, 0, 0, 0);
        step("clutch",    1'b1, 4'b0010, 2'b00, 2'b01, 0, 0, 0, 0);
        step("brake",     1'b1, 4'b0001, 2'b00, 2'b00, 0, 0, 0, 0);
        step("start_r",   1'b1, 4'b1110, 2'b00, 2'b01, 0, 0, 0, 0);
        step("go_bwd",    1'b1, 4'b1100, 2'b00, 2'b10, 0, 1, 0, 0);
        step("left",      1'b1, 4'b0100, 2'b10, 2'b10, 0, 1, 1, 0);
        step("right",     1'b1, 4'b0100, 2'b01, 2'b10, 0, 1, 0, 1);
        step("both",      1'b1, 4'b0100, 2'b11, 2'b10, 0, 1, 0, 0);
        step("none",      1'b1, 4'b0100, 2'b00, 2'b10, 0, 1, 0, 0);
        step("m_brake",   1'b1, 4'b1101, 2'b00, 2'b00, 0, 0, 0, 0);
        step("thr_only",  1'b1, 4'b1000, 2'b00, 2'b00, 0, 0, 0, 0);
        step("ns_left",   1'b1, 4'b0000, 2'b10, 2'b00, 0, 0, 0, 0);
        step("start2",    1'b1, 4'b1010, 2'b00, 2'b01, 0, 0, 0, 0);
        step("s_brk_thr", 1'b1, 4'b1001, 2'b00, 2'b00, 0, 0, 0, 0);
        step("start3",    1'b1, 4'b1010, 2'b00, 2'b01, 0, 0, 0, 0);
        step("go_fwd2",   1'b1, 4'b1000, 2'b00, 2'b10, 1, 0, 0, 0);
`ifdef MANUAL_REVERSE_STALL_EN
        step("rev_stall", 1'b1, 4'b1100, 2'b00, 2'b00, 0, 0, 0, 0);
        step("start4",    1'b1, 4'b1010, 2'b00, 2'b01, 0, 0, 0, 0);
        step("go_fwd3",   1'b1, 4'b1000, 2'b00, 2'b10, 1, 0, 0, 0);
`else
        step("rev_ign",   1'b1, 4'b1100, 2'b00, 2'b10, 1, 0, 0, 0);
`endif
        step("coast_l",   1'b1, 4'b0000, 2'b10, 2'b10, 1, 0, 1, 0);
        step("disable",   1'b0, 4'b0000, 2'b10, 2'b00, 0, 0, 0, 0);
        step("start5",    1'b1, 4'b1010, 2'b00, 2'b01, 0, 0, 0, 0);
        step("go_fwd4",   1'b1, 4'b1000, 2'b01, 2'b10, 1, 0, 0, 1);

        // Asynchronous reset in the middle of a cycle while moving.
        #2;
        rst = 1'b1;
        #1;
        chk("arst.state", dif.state, 2'b00);
        chk("arst.fwd", {1'b0, dif.move_forward_signal}, 2'b00);
        chk("arst.tr", {1'b0, dif.turn_right_signal}, 2'b00);
        $display("step %-10s state=%0d f=%0b r=%0b", "async_rst", dif.state,
                 dif.move_forward_signal, dif.turn_right_signal);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step("after_rst", 1'b1, 4'b1010, 2'b00, 2'b01, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
